// File: rtl/channel_mux_pkg.sv
// Shared constants and helpers for the channel arbiter/mux slice.
package channel_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Channel-index width; never narrower than one bit.
  function automatic int unsigned selw(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/channel_arb_mux_if.sv
// Handshake bundle between NCH producers, the arbiter/mux and one consumer.
interface channel_arb_mux_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NCH   = 4
);
  localparam int unsigned SELW = channel_mux_pkg::selw(NCH);

  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester searching upward from last+1, wrapping at NCH-1.
module rr_arbiter #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned SELW = 2
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] last,
  output logic [SELW-1:0] grant,
  output logic            grant_valid
);

  logic [SELW-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      idx = SELW'((32'(last) + i) % NCH);
      if (!grant_valid && req[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/channel_arb_mux.sv
// NCH-to-1 channel mux with fixed or round-robin selection and a one-word output register.
module channel_arb_mux
  import channel_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NCH   = 4
) (
  input logic               clk,
  input logic               rst_n,
  channel_arb_mux_if.slave  bus
);

  localparam int unsigned SELW = selw(NCH);

  logic [SELW-1:0]  last_q;
  logic [SELW-1:0]  rr_grant;
  logic             rr_valid;
  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic             fixed_valid;
  logic             load;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] data_q;
  logic [SELW-1:0]  ch_q;
  logic             valid_q;

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_rr_arbiter (
    .req         (bus.in_valid),
    .last        (last_q),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  always_comb begin
    fixed_valid = 1'b0;
    word        = '0;
    // Compare rather than index so an out-of-range sel simply matches nothing.
    for (int unsigned k = 0; k < NCH; k++) begin
      if (32'(bus.sel) == k) fixed_valid = bus.in_valid[k];
    end
    if (bus.mode == MODE_RR) begin
      grant       = rr_grant;
      grant_valid = rr_valid;
    end else begin
      grant       = bus.sel;
      grant_valid = fixed_valid;
    end
    for (int unsigned k = 0; k < NCH; k++) begin
      if (32'(grant) == k) word = bus.in_data[k*WIDTH +: WIDTH];
    end
    // Gated by rst_n so nothing is accepted while reset is held.
    load         = rst_n & (~valid_q | bus.out_ready);
    bus.in_ready = '0;
    if (load && grant_valid) bus.in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= SELW'(NCH - 1);
    end else if (load) begin
      if (grant_valid) begin
        data_q  <= word;
        ch_q    <= grant;
        valid_q <= 1'b1;
        if (bus.mode == MODE_RR) last_q <= grant;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_channel_arb_mux.sv
// Scoreboard bench for channel_arb_mux: NCH=4 main instance plus an NCH=3 instance for range checks.
module tb_channel_arb_mux;

  localparam int unsigned W = 4;
  localparam int unsigned N = 4;

  typedef struct {
    int ch;
    int data;
  } word_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  channel_arb_mux_if #(.WIDTH(W), .NCH(N)) bus ();
  channel_arb_mux_if #(.WIDTH(W), .NCH(3)) bus3 ();

  channel_arb_mux #(.WIDTH(W), .NCH(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  channel_arb_mux #(.WIDTH(W), .NCH(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  word_t exp_q[$];
  int    exp_last;
  int    checks = 0;
  int    errors = 0;
  int    wait_cnt[N];

  function automatic int model_grant();
    int k;
    if (bus.mode == 1'b0) begin
      if (int'(bus.sel) < N && bus.in_valid[bus.sel]) return int'(bus.sel);
      return -1;
    end
    for (int i = 1; i <= N; i++) begin
      k = (exp_last + i) % N;
      if (bus.in_valid[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic model_load();
    return rst_n && (exp_q.size() == 0 || bus.out_ready);
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = model_grant();
    if (model_load() && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // Advance the model across one rising edge, then park at the next falling edge.
  task automatic tick();
    int   g;
    logic ld;
    word_t w;
    g  = model_grant();
    ld = model_load();
    if (exp_q.size() > 0 && bus.out_ready) void'(exp_q.pop_front());
    if (ld && g >= 0) begin
      w.ch   = g;
      w.data = int'(bus.in_data[g*W +: W]);
      exp_q.push_back(w);
      if (bus.mode == 1'b1) exp_last = g;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_last = N - 1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.in_valid = '1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_ch !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h ch=%0d want 0/0/0",
               bus.out_valid, bus.out_data, bus.out_ch);
    end
    checks++;
    if (bus.in_ready !== 4'b0000 || bus3.in_ready !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready: got %b/%b want 0000/000", bus.in_ready, bus3.in_ready);
    end
    exp_q.delete();
    exp_last = N - 1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fixed();
    bus.mode      = 1'b0;
    bus.sel       = 2'd2;
    bus.in_data   = 16'h3210;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL fixed_ready: got %b want 0100", bus.in_ready);
    end
    tick();
    bus.sel      = 2'd3;
    bus.in_valid = 4'b0111;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd2 || bus.out_ch !== 2'd2) begin
      errors++;
      $display("FAIL fixed_out: got v=%b d=%0d ch=%0d want 1/2/2",
               bus.out_valid, bus.out_data, bus.out_ch);
    end
    checks++;
    if (bus.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL fixed_invalid_sel_ready: got %b want 0000", bus.in_ready);
    end
    tick();
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 4'd2) begin
      errors++;
      $display("FAIL fixed_no_grant: got v=%b d=%0d want 0/2", bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_rr_rotation();
    int seq[5] = '{0, 1, 2, 3, 0};
    do_reset();
    bus.mode      = 1'b1;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      bus.in_data = 16'($urandom());
      #1;
      checks++;
      if (bus.in_ready !== exp_ready()) begin
        errors++;
        $display("FAIL rr_ready[%0d]: got %b want %b", i, bus.in_ready, exp_ready());
      end
      if (i >= 1) begin
        checks++;
        if (bus.out_valid !== 1'b1 || int'(bus.out_ch) != seq[i-1] ||
            int'(bus.out_data) != exp_q[0].data) begin
          errors++;
          $display("FAIL rr_seq[%0d]: got v=%b ch=%0d d=%0d want 1/%0d/%0d", i, bus.out_valid,
                   bus.out_ch, bus.out_data, seq[i-1], exp_q[0].data);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.mode      = 1'b1;
    bus.in_valid  = 4'b1010;
    bus.in_data   = 16'hA5C3;
    bus.out_ready = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_first_ready: got %b want 0010", bus.in_ready);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      // Mode/sel churn during the stall must not disturb the held word.
      bus.mode = (i == 1) ? 1'b0 : 1'b1;
      bus.sel  = 2'(i + 1);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd1 || bus.out_data !== 4'hC ||
          bus.in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b ch=%0d d=%h rdy=%b want 1/1/c/0000", i,
                 bus.out_valid, bus.out_ch, bus.out_data, bus.in_ready);
      end
      tick();
    end
    bus.mode      = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_release_ready: got %b want 1000", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd3 || bus.out_data !== 4'hA) begin
      errors++;
      $display("FAIL bp_release_out: got v=%b ch=%0d d=%h want 1/3/a",
               bus.out_valid, bus.out_ch, bus.out_data);
    end
    bus.in_valid = '0;
    tick();
  endtask

  task automatic test_nch3();
    bus3.mode      = 1'b0;
    bus3.sel       = 2'd3;
    bus3.in_valid  = 3'b111;
    bus3.in_data   = 12'h210;
    bus3.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus3.out_valid !== 1'b0 || bus3.in_ready !== 3'b000) begin
        errors++;
        $display("FAIL nch3_sel3[%0d]: got v=%b rdy=%b want 0/000", i,
                 bus3.out_valid, bus3.in_ready);
      end
      tick();
    end
    bus3.sel = 2'd1;
    #1;
    checks++;
    if (bus3.in_ready !== 3'b010) begin
      errors++;
      $display("FAIL nch3_sel1_ready: got %b want 010", bus3.in_ready);
    end
    tick();
    checks++;
    if (bus3.out_valid !== 1'b1 || bus3.out_data !== 4'd1 || bus3.out_ch !== 2'd1) begin
      errors++;
      $display("FAIL nch3_sel1_out: got v=%b d=%0d ch=%0d want 1/1/1",
               bus3.out_valid, bus3.out_data, bus3.out_ch);
    end
    bus3.in_valid = '0;
  endtask

  task automatic test_reset_midflight();
    bus.mode      = 1'b1;
    bus.in_valid  = 4'b1111;
    bus.in_data   = 16'h4321;
    bus.out_ready = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_loaded: got v=%b want 1", bus.out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 4'd0 || bus.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_async: got v=%b d=%0d rdy=%b want 0/0/0000",
               bus.out_valid, bus.out_data, bus.in_ready);
    end
    exp_q.delete();
    exp_last = N - 1;
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midreset_first_grant: got %b want 0001", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd0 || bus.out_data !== 4'd1) begin
      errors++;
      $display("FAIL midreset_first_out: got v=%b ch=%0d d=%0d want 1/0/1",
               bus.out_valid, bus.out_ch, bus.out_data);
    end
  endtask

  task automatic test_random();
    int   g;
    logic ld;
    for (int k = 0; k < N; k++) wait_cnt[k] = 0;
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) bus.mode = 1'($urandom());
      bus.sel       = 2'($urandom());
      bus.in_valid  = 4'($urandom());
      bus.in_data   = 16'($urandom());
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if (c >= 590) begin
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
      end
      #1;
      checks++;
      if (bus.in_ready !== exp_ready()) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b want %b", c, bus.in_ready, exp_ready());
      end
      checks++;
      if (bus.out_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL rand_valid[%0d]: got %b want %b", c, bus.out_valid, exp_q.size() != 0);
      end else if (exp_q.size() != 0) begin
        checks++;
        if (int'(bus.out_ch) != exp_q[0].ch || int'(bus.out_data) != exp_q[0].data) begin
          errors++;
          $display("FAIL rand_word[%0d]: got ch=%0d d=%0d want ch=%0d d=%0d", c,
                   bus.out_ch, bus.out_data, exp_q[0].ch, exp_q[0].data);
        end
      end
      g  = model_grant();
      ld = model_load();
      if (bus.mode == 1'b1 && ld && g >= 0) begin
        for (int k = 0; k < N; k++) begin
          if (!bus.in_valid[k] || k == g) begin
            wait_cnt[k] = 0;
          end else begin
            wait_cnt[k]++;
            checks++;
            if (wait_cnt[k] >= N) begin
              errors++;
              $display("FAIL rand_starve ch%0d: got %0d waits want < %0d", k, wait_cnt[k], N);
            end
          end
        end
      end else if (bus.mode == 1'b0) begin
        for (int k = 0; k < N; k++) wait_cnt[k] = 0;
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain: got v=%b pending=%0d want 0/0", bus.out_valid, exp_q.size());
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.in_data    = '0;
    bus.in_valid   = '0;
    bus.mode       = 1'b0;
    bus.sel        = '0;
    bus.out_ready  = 1'b0;
    bus3.in_data   = '0;
    bus3.in_valid  = '0;
    bus3.mode      = 1'b0;
    bus3.sel       = '0;
    bus3.out_ready = 1'b1;
    test_reset();
    test_fixed();
    test_rr_rotation();
    test_backpressure();
    test_nch3();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
